spi_frame_monitor: RTL
======================

// Module: spi_frame_monitor
// PURPOSE
//  Synthesisable, parametrised SPI-slave bus monitor. Taps SS_n/MOSI/MISO next to the SPI slave wrapper.
//  Reconstructs frames: 2-bit command + DATA_W data bits on MOSI, then DATA_W bits on MISO for read-data.
//  Reports decoded frames and read-back data, and flags protocol violations with sticky flags and counters.
//  Used on silicon debug and as a scoreboard front-end in the wrapper bench.
// PARAMETERS
//  DATA_W      8  payload bits per frame; MOSI frame length is DATA_W+2
//  RD_LATENCY  1  turnaround clks between last MOSI bit and first MISO bit (>=0)
//  CNT_W      16  width of frame/error counters (saturating)
//  CHECK_MISO  1  1 = enable MISO-stability check outside read-out window
// PORTS
//  clk          in   1         single clock, all sampling on posedge
//  rst          in   1         synchronous, active-high reset
//  SS_n         in   1         slave select, active low
//  MOSI         in   1         master data, MSB first
//  MISO         in   1         slave data, MSB first
//  err_clr      in   1         clears all sticky err_* flags (counters not cleared)
//  frame_valid  out  1         1-clk pulse: complete MOSI frame decoded
//  frame_cmd    out  2         command of last frame (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data)
//  frame_data   out  DATA_W    payload of last frame
//  rd_valid     out  1         1-clk pulse: read-out captured
//  rd_data      out  DATA_W    MISO bits of last read-out
//  err_short    out  1         sticky: SS_n rose before frame or read-out finished
//  err_long     out  1         sticky: SS_n stayed low past end of frame
//  err_rd_order out  1         sticky: rd-data (11) without preceding rd-addr (10)
//  err_miso     out  1         sticky: MISO toggled outside read-out window
//  frame_cnt    out  CNT_W     count of frame_valid pulses
//  err_cnt      out  CNT_W     count of error events (each flag-setting event counts once)
// BEHAVIOUR
//  Reset: every output 0; state IDLE; bit counter 0; rd_addr_seen 0.
//  Reset mid-frame aborts silently: no error, no pulse.
//  FSM states and transitions:
//   IDLE: first edge with SS_n=0 samples MOSI as bit DATA_W+1 (cmd MSB); go to SHIFT.
//   SHIFT: sample one MOSI bit per clk until DATA_W+2 bits are taken.
//    After the last bit: frame_valid=1 on the next clk, with frame_cmd/frame_data updated in that same clk.
//    Next state is TURN if cmd==11, otherwise DONE.
//   TURN: RD_LATENCY clks, MISO ignored; RD_LATENCY=0 skips TURN.
//   RDOUT: sample DATA_W MISO bits; rd_valid/rd_data 1 clk after the last bit; then DONE.
//   DONE: SS_n=1 -> IDLE. SS_n=0 -> set err_long once per frame and stay in DONE.
//   SS_n=1 while in SHIFT/TURN/RDOUT: set err_short, go to IDLE.
//    No frame_valid is issued if still in SHIFT. No rd_valid is issued.
//  rd_addr_seen:
//   Set by a cmd=10 frame; cleared by a cmd=11 frame.
//   A cmd=11 frame with rd_addr_seen=0 sets err_rd_order; frame is still reported and read-out still monitored.
//  MISO check (CHECK_MISO=1):
//   MISO!=previous sample, with both this and the previous clk outside RDOUT -> set err_miso.
//   First clk after reset is exempt.
//  Sticky flags: err_clr and a new error in the same clk -> flag stays 1, err_cnt still increments.
//  Counters saturate at all-ones; never wrap.
//  Single-clk SS_n high between frames is legal: DONE->IDLE, next low starts a new frame.
//  frame_cmd/frame_data/rd_data hold until overwritten.
// TESTING (DATA_W=8, RD_LATENCY=1)
//  rst=1 for 2 clks mid-SHIFT -> all outputs 0, no pulses, state IDLE after release.
//  wr-addr frame 00_1010_0101 then SS_n=1 -> frame_valid, cmd=00, data=0xA5, frame_cnt=1, no errors.
//  rd-addr 10_0000_0011, then rd-data 11_xxxx_xxxx with MISO=0x3C after 1 turnaround clk -> rd_valid, rd_data=0x3C, no errors.
//  rd-data frame straight after reset -> err_rd_order=1, err_cnt=1; err_clr -> flag 0, err_cnt stays 1.
//  SS_n high after 6 MOSI bits -> err_short=1, no frame_valid.
//    Separately: SS_n held low 3 clks past end of wr frame -> err_long=1, err_cnt+1 only once.
//  MISO toggled during wr-data frame -> err_miso=1; with CHECK_MISO=0 -> stays 0.

Source files
------------

// File: rtl/spi_frame_monitor_if.sv
// Signal bundle between an SPI bus tap and the frame monitor.
// The master side drives the bus taps; the slave side is the monitor.
interface spi_frame_monitor_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic              err_clr;
    logic              frame_valid;
    logic [1:0]        frame_cmd;
    logic [DATA_W-1:0] frame_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              err_short;
    logic              err_long;
    logic              err_rd_order;
    logic              err_miso;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output SS_n, MOSI, MISO, err_clr,
        input  frame_valid, frame_cmd, frame_data,
        input  rd_valid, rd_data,
        input  err_short, err_long, err_rd_order, err_miso,
        input  frame_cnt, err_cnt
    );

    modport slave (
        input  SS_n, MOSI, MISO, err_clr,
        output frame_valid, frame_cmd, frame_data,
        output rd_valid, rd_data,
        output err_short, err_long, err_rd_order, err_miso,
        output frame_cnt, err_cnt
    );
endinterface

// File: rtl/spi_frame_monitor.sv
// SPI slave bus monitor: rebuilds cmd/data frames and MISO read-outs,
// and raises sticky protocol-violation flags with saturating counters.
module spi_frame_monitor #(
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16,
    parameter bit CHECK_MISO = 1'b1
) (
    input logic clk,
    input logic rst,
    spi_frame_monitor_if.slave bus
);
    localparam int FRM_W = DATA_W + 2;
    localparam int CW    = $clog2(FRM_W + RD_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, TURN, RDOUT, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FRM_W-1:0]  sh_q, sh_d, frm;
    logic [1:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              fv_q, fv_d;
    logic              rv_q, rv_d;
    logic              seen_q, seen_d;
    logic              long_q, long_d;
    logic              miso_q, mvld_q, prd_q;
    // err bits: 0 short, 1 long, 2 rd_order, 3 miso
    logic [3:0]        err_q, err_d, ev;
    logic [2:0]        ev_n;
    logic [CNT_W:0]    esum;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d, ecnt_q, ecnt_d;

    // MOSI and MISO share one shift register; RDOUT selects MISO.
    assign frm = {sh_q[FRM_W-2:0], (state_q == RDOUT) ? bus.MISO : bus.MOSI};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        rdat_d  = rdat_q;
        fv_d    = 1'b0;
        rv_d    = 1'b0;
        seen_d  = seen_q;
        long_d  = long_q;
        ev      = 4'b0000;

        unique case (state_q)
            IDLE: begin
                if (!bus.SS_n) begin
                    sh_d    = frm;
                    cnt_d   = CW'(1);
                    long_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.SS_n) begin
                    ev[0]   = 1'b1;
                    state_d = IDLE;
                end else begin
                    sh_d  = frm;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(FRM_W - 1)) begin
                        fv_d   = 1'b1;
                        cmd_d  = frm[FRM_W-1 -: 2];
                        data_d = frm[DATA_W-1:0];
                        cnt_d  = '0;
                        if (frm[FRM_W-1 -: 2] == 2'b11) begin
                            ev[2]   = ~seen_q;
                            seen_d  = 1'b0;
                            state_d = (RD_LATENCY == 0) ? RDOUT : TURN;
                        end else begin
                            if (frm[FRM_W-1 -: 2] == 2'b10)
                                seen_d = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            TURN: begin
                if (bus.SS_n) begin
                    ev[0]   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CW'(RD_LATENCY - 1)) begin
                    cnt_d   = '0;
                    state_d = RDOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RDOUT: begin
                if (bus.SS_n) begin
                    ev[0]   = 1'b1;
                    state_d = IDLE;
                end else begin
                    sh_d  = frm;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_W - 1)) begin
                        rv_d    = 1'b1;
                        rdat_d  = frm[DATA_W-1:0];
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.SS_n) begin
                    state_d = IDLE;
                end else if (!long_q) begin
                    ev[1]  = 1'b1;
                    long_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ev[3] = CHECK_MISO && mvld_q && !prd_q &&
                (state_q != RDOUT) && (bus.MISO != miso_q);

        err_d  = (err_q & ~{4{bus.err_clr}}) | ev;
        ev_n   = 3'(ev[0]) + 3'(ev[1]) + 3'(ev[2]) + 3'(ev[3]);
        esum   = {1'b0, ecnt_q} + (CNT_W+1)'(ev_n);
        ecnt_d = esum[CNT_W] ? '1 : esum[CNT_W-1:0];
        fcnt_d = (fv_d && fcnt_q != '1) ? fcnt_q + CNT_W'(1) : fcnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            rdat_q  <= '0;
            fv_q    <= 1'b0;
            rv_q    <= 1'b0;
            seen_q  <= 1'b0;
            long_q  <= 1'b0;
            miso_q  <= 1'b0;
            mvld_q  <= 1'b0;
            prd_q   <= 1'b0;
            err_q   <= '0;
            fcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            rdat_q  <= rdat_d;
            fv_q    <= fv_d;
            rv_q    <= rv_d;
            seen_q  <= seen_d;
            long_q  <= long_d;
            miso_q  <= bus.MISO;
            mvld_q  <= 1'b1;
            prd_q   <= (state_q == RDOUT);
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign bus.frame_valid  = fv_q;
    assign bus.frame_cmd    = cmd_q;
    assign bus.frame_data   = data_q;
    assign bus.rd_valid     = rv_q;
    assign bus.rd_data      = rdat_q;
    assign bus.err_short    = err_q[0];
    assign bus.err_long     = err_q[1];
    assign bus.err_rd_order = err_q[2];
    assign bus.err_miso     = err_q[3];
    assign bus.frame_cnt    = fcnt_q;
    assign bus.err_cnt      = ecnt_q;
endmodule
